// File: rtl/fx3_sf_pkg.sv
// Shared constants for the FX3 slave-FIFO responder: socket addresses and
// bit positions inside the sticky error vector.
package fx3_sf_pkg;

  localparam logic [1:0] ADDR_RD_SOCK = 2'b11;  // FX3 -> FPGA socket
  localparam logic [1:0] ADDR_WR_SOCK = 2'b00;  // FPGA -> FX3 socket

  localparam int unsigned ERR_UDF  = 0;  // read from empty read socket
  localparam int unsigned ERR_OVF  = 1;  // write into full write socket
  localparam int unsigned ERR_ADDR = 2;  // wrong socket or read+write together

endpackage

// File: rtl/sf_sync_fifo.sv
// Single-clock FIFO backing one slave-FIFO socket. The head word is presented
// combinationally (first-word-fall-through), occupancy is exported for flags.
module sf_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk_pll,
  input  logic                     reset_,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Storage array; left without reset so it maps onto RAM.
  always_ff @(posedge clk_pll) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally; occupancy is unchanged on simultaneous push+pop.
  always_ff @(posedge clk_pll or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fx3_slave_fifo_responder.sv
// FX3 side of the GPIF-II synchronous slave-FIFO interface: one read socket
// loaded by the host, one write socket drained by the host, registered flags,
// a two-stage read data path and sticky error reporting.
module fx3_slave_fifo_responder
  import fx3_sf_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned RD_WATERMARK = 4,
  parameter int unsigned WR_WATERMARK = 6
) (
  input  logic        clk_pll,
  input  logic        reset_,
  input  logic        slcs_n,
  input  logic        slrd_n,
  input  logic        slwr_n,
  input  logic        sloe_n,
  input  logic        pktend_n,
  input  logic [1:0]  addr,
  input  logic [31:0] dq_in,
  output logic [31:0] dq_out,
  output logic        dq_oe,
  output logic        flaga,
  output logic        flagb,
  output logic        flagc,
  output logic        flagd,
  input  logic        h_tx_valid,
  output logic        h_tx_ready,
  input  logic [31:0] h_tx_data,
  output logic        h_rx_valid,
  input  logic        h_rx_ready,
  output logic [31:0] h_rx_data,
  output logic [15:0] pktend_cnt,
  output logic [2:0]  err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] RD_WM   = CW'(RD_WATERMARK);
  localparam logic [CW-1:0] WR_WM   = CW'(WR_WATERMARK);

  logic [CW-1:0] rd_cnt, wr_cnt;
  logic          rd_full, rd_empty, wr_full, wr_empty;
  logic [31:0]   rd_head;
  logic [31:0]   rd_stage;
  logic          rd_stage_vld;
  logic          slwr_n_q;

  logic slave_rd, slave_wr, rd_sel, wr_sel;
  logic rd_hit, wr_hit;
  logic rd_pop, rd_udf, wr_push, wr_ovf, addr_bad, pkt;
  logic tx_push, rx_pop;

  assign slave_rd = ~slcs_n & ~slrd_n;
  assign slave_wr = ~slcs_n & ~slwr_n;
  assign rd_sel   = slave_rd & ~slave_wr;
  assign wr_sel   = slave_wr & ~slave_rd;
  assign rd_hit   = rd_sel & (addr == ADDR_RD_SOCK);
  assign wr_hit   = wr_sel & (addr == ADDR_WR_SOCK);
  assign rd_pop   = rd_hit & ~rd_empty;
  assign rd_udf   = rd_hit & rd_empty;
  assign wr_push  = wr_hit & ~wr_full;
  assign wr_ovf   = wr_hit & wr_full;
  assign addr_bad = (slave_rd & slave_wr)
                  | (rd_sel & (addr != ADDR_RD_SOCK))
                  | (wr_sel & (addr != ADDR_WR_SOCK));
  assign pkt      = ~slcs_n & ~pktend_n & slwr_n & (addr == ADDR_WR_SOCK);

  assign h_tx_ready = ~rd_full;
  assign tx_push    = h_tx_valid & h_tx_ready;
  assign rx_pop     = h_rx_valid & h_rx_ready;

  assign dq_oe = ~slcs_n & ~sloe_n & ~slwr_n_q;

  sf_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_rd_fifo (
    .clk_pll   (clk_pll),
    .reset_    (reset_),
    .push      (tx_push),
    .push_data (h_tx_data),
    .pop       (rd_pop),
    .head_data (rd_head),
    .count     (rd_cnt),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  sf_sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_wr_fifo (
    .clk_pll   (clk_pll),
    .reset_    (reset_),
    .push      (wr_push),
    .push_data (dq_in),
    .pop       (rx_pop),
    .head_data (h_rx_data),
    .count     (wr_cnt),
    .full      (wr_full),
    .empty     (wr_empty)
  );

  // Read path: popped word is staged, then lands on dq_out one edge later.
  always_ff @(posedge clk_pll or negedge reset_) begin
    if (!reset_) begin
      rd_stage     <= '0;
      rd_stage_vld <= 1'b0;
      dq_out       <= '0;
    end else begin
      rd_stage_vld <= rd_pop;
      if (rd_pop)       rd_stage <= rd_head;
      if (rd_stage_vld) dq_out   <= rd_stage;
    end
  end

  // Flags follow the occupancy held since the previous edge.
  always_ff @(posedge clk_pll or negedge reset_) begin
    if (!reset_) begin
      flaga <= 1'b1;
      flagb <= 1'b1;
      flagc <= 1'b0;
      flagd <= 1'b0;
    end else begin
      flaga <= (wr_cnt != DEPTH_C);
      flagb <= ((DEPTH_C - wr_cnt) > WR_WM);
      flagc <= (rd_cnt != '0);
      flagd <= (rd_cnt > RD_WM);
    end
  end

  // Sticky errors, PKEND counter, write-strobe history and host drain valid.
  // h_rx_valid rises one edge after the first word lands but drops on the same
  // edge that drains the last word, so it never advertises an empty buffer.
  always_ff @(posedge clk_pll or negedge reset_) begin
    if (!reset_) begin
      err        <= '0;
      pktend_cnt <= '0;
      slwr_n_q   <= 1'b1;
      h_rx_valid <= 1'b0;
    end else begin
      err[ERR_ADDR] <= err[ERR_ADDR] | addr_bad;
      err[ERR_OVF]  <= err[ERR_OVF]  | wr_ovf;
      err[ERR_UDF]  <= err[ERR_UDF]  | rd_udf;
      if (pkt) pktend_cnt <= pktend_cnt + 16'd1;
      slwr_n_q   <= slwr_n;
      h_rx_valid <= ~wr_empty & ~(rx_pop & ~wr_push & (wr_cnt == CW'(1)));
    end
  end

endmodule
